share_pipe_reg: RTL and testbench
=================================

Name: share_pipe_reg

Overview:
- Parametrised, elastic register pipeline for masked values: SHARES independent shares of WIDTH bits each, held through DEPTH stages.
- Adds valid/ready handshaking, bubble collapse, flush and occupancy reporting.
- Gadget outputs use it to re-register shares, to balance pipeline depth between composed gadgets, and to decouple producers from stalled consumers.
- Shares are never combined; every bit follows its own register path.

Parameters:
SHARES, 2, number of shares per value (>=1)
WIDTH, 1, bits per share (>=1)
DEPTH, 1, number of register stages (>=1; 0 is illegal and must be rejected at elaboration)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
in_valid  input  1  upstream value present
in_ready  output  1  stage 0 can accept this cycle
in_data  input  SHARES*WIDTH  share s at bits [s*WIDTH +: WIDTH]
out_valid  output  1  last stage holds a value
out_ready  input  1  downstream accepts this cycle
out_data  output  SHARES*WIDTH  last stage data, same packing
flush  input  1  synchronous discard of all held values
occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- State per stage i (0..DEPTH-1): v[i] (1 bit) and d[i] (SHARES*WIDTH bits).
- Reset, asynchronous on rst_n=0: all v[i]=0 and all d[i]=0 immediately, independent of clk. Result: out_valid=0, out_data=0, occupancy=0, and in_ready=1 (flush=0).
- Ready chain, combinational:
  - r[DEPTH] = out_ready
  - r[i] = !v[i] | r[i+1]
  - in_ready = r[0] & !flush
- Advance on each clk edge when flush=0:
  - Stage 0: if r[0], then v[0] <= in_valid. If additionally in_valid=1, d[0] <= in_data.
  - Stage i>0: if r[i], then v[i] <= v[i-1]. If additionally v[i-1]=1, d[i] <= d[i-1].
  - Any stage with r[i]=0 holds both v[i] and d[i].
- d[i] loads only on an accepted transfer. Invalid stages keep stale data; it is never cleared except by reset.
- out_valid = v[DEPTH-1] & !flush. out_data = d[DEPTH-1], a direct register output with no logic between register and port.
- Latency with no backpressure: a value accepted at edge k appears on out_valid/out_data after edge k+DEPTH-1, i.e. DEPTH cycles after presentation.
- Throughput: one value per cycle while out_ready=1.
- Bubble collapse: an empty stage accepts even when downstream stalls. A full pipe with out_ready=0 holds DEPTH values and drives in_ready=0.
- Simultaneous pop and push on a full pipe: allowed in the same cycle (in_ready=1 when out_ready=1).
- Flush:
  - When flush=1 at an edge, all v[i] <= 0 and d[i] is unchanged.
  - While flush=1, in_ready=0 and out_valid=0, so no handshake completes in a flush cycle.
  - in_valid is ignored.
  - flush overrides every simultaneous push and pop.
- occupancy: combinational population count of v[].
- Share isolation:
  - No gate takes inputs from more than one share.
  - Control logic (v, r) never depends on data.
  - Enables are shared across shares only as control.
- Reset mid-transfer: held values are lost with no partial output. After rst_n rises, the first accepted input appears after DEPTH cycles.

Test Plan:
- Reset/idle, SHARES=2, WIDTH=4, DEPTH=3: assert rst_n=0 mid-cycle -> out_valid, out_data and occupancy drop to 0 before the next edge; after release, in_ready=1.
- Streaming, out_ready=1: push 0x5A, 0x3C, 0x81 on consecutive cycles -> identical values on out_data with out_valid=1 on the 3rd, 4th and 5th cycle after the first push; occupancy peaks at 3.
- Backpressure/bubble collapse: out_ready=0, push 0x11 then (idle cycle) 0x22, 0x33 -> occupancy reaches 3 with no loss and in_ready=0. Then raise out_ready -> outputs 0x11, 0x22, 0x33 in order.
- Full-pipe pass-through: full pipe, out_ready=1 and in_valid=1 with 0x44 -> pop and push in the same cycle; occupancy stays 3.
- Flush: pipe holding 2 values, assert flush=1 with in_valid=1 (0x77) -> in_ready=0, out_valid=0 during flush; occupancy=0 after the edge; 0x77 never appears at the output.
- Share isolation, SHARES=3, WIDTH=1, DEPTH=1: drive each share independently with random bits -> each output share equals its own input one cycle later. A per-share toggle test confirms no cross-share influence.

Source files
------------

// File: rtl/share_pipe_reg.sv
// share_pipe_reg: elastic DEPTH-stage register pipeline for SHARES-way masked values
// with valid/ready handshake, bubble collapse, flush and occupancy count.
module share_pipe_reg #(
   parameter int SHARES = 2,
   parameter int WIDTH  = 1,
   parameter int DEPTH  = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [SHARES*WIDTH-1:0]      in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SHARES*WIDTH-1:0]      out_data,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
   localparam int N  = SHARES * WIDTH;
   localparam int OW = $clog2(DEPTH + 1);
   if (DEPTH < 1 || SHARES < 1 || WIDTH < 1) begin : g_bad_param
      $error("share_pipe_reg: SHARES, WIDTH and DEPTH must all be >= 1");
   end
   logic [DEPTH-1:0] v_q, v_d, v_prev, ld;
   logic [DEPTH:0]   r;
   logic [N-1:0]     d_q    [DEPTH];
   logic [N-1:0]     d_d    [DEPTH];
   logic [N-1:0]     d_prev [DEPTH];
   // Ready ripples back from the output; an empty stage is always ready.
   always_comb begin
      r[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) r[i] = !v_q[i] | r[i+1];
   end
   // Data muxes are per bit; only the control enables fan out across shares.
   always_comb begin
      v_prev[0] = in_valid;
      d_prev[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         v_prev[i] = v_q[i-1];
         d_prev[i] = d_q[i-1];
      end
      for (int i = 0; i < DEPTH; i++) begin
         ld[i]  = !flush & r[i] & v_prev[i];
         v_d[i] = flush ? 1'b0 : r[i] ? v_prev[i] : v_q[i];
         d_d[i] = ld[i] ? d_prev[i] : d_q[i];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
      end else begin
         v_q <= v_d;
         for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
      end
   end
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(v_q[i]);
   end
   assign in_ready  = r[0] & !flush;
   assign out_valid = v_q[DEPTH-1] & !flush;
   assign out_data  = d_q[DEPTH-1];
endmodule

// File: tb/tb_share_pipe_reg.sv
// tb_share_pipe_reg: directed and randomized checks of share_pipe_reg against a
// queue-based model of an elastic FIFO-like pipeline with fixed minimum latency.
module tb_share_pipe_reg;
   localparam int S  = 2;
   localparam int W  = 4;
   localparam int D  = 3;
   localparam int N  = S * W;
   localparam int OW = $clog2(D + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic in_ready, out_valid;
   logic [N-1:0] in_data = '0;
   logic [N-1:0] out_data;
   logic [OW-1:0] occupancy;

   logic i_in_valid = 1'b0, i_out_ready = 1'b0, i_flush = 1'b0;
   logic i_in_ready, i_out_valid;
   logic [2:0] i_in_data = '0;
   logic [2:0] i_out_data;
   logic [0:0] i_occupancy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   share_pipe_reg #(.SHARES(S), .WIDTH(W), .DEPTH(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .flush(flush), .occupancy(occupancy)
   );

   share_pipe_reg #(.SHARES(3), .WIDTH(1), .DEPTH(1)) u_iso (
      .clk(clk), .rst_n(rst_n), .in_valid(i_in_valid), .in_ready(i_in_ready),
      .in_data(i_in_data), .out_valid(i_out_valid), .out_ready(i_out_ready),
      .out_data(i_out_data), .flush(i_flush), .occupancy(i_occupancy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (i_occupancy !== 1'b0 || i_out_valid !== 1'b0) begin errors++; $display("FAIL reset_iso got occ=%b v=%b want 0 0", i_occupancy, i_out_valid); end
      #3 rst_n = 1'b1;
      tick;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data = N'(8'hE1 - 8'h0F * k);
         tick;
      end
      in_valid = 1'b0;
      tick;
      checks++; if (occupancy !== OW'(3) || out_valid !== 1'b1) begin errors++; $display("FAIL prereset_full got occ=%0d v=%b want 3 1", occupancy, out_valid); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL async_reset_out_data got %h want 0", out_data); end
      checks++; if (occupancy !== '0) begin errors++; $display("FAIL async_reset_occupancy got %0d want 0", occupancy); end
      #3 rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
      tick;
   endtask

   task automatic test_stream;
      logic [N-1:0] vals [3];
      int maxocc;
      int eocc;
      vals[0] = 8'h5A; vals[1] = 8'h3C; vals[2] = 8'h81;
      maxocc = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_valid = (c < 3);
         in_data = (c < 3) ? vals[c] : '0;
         #1;
         eocc = 0;
         for (int j = 0; j < 3; j++) if (c >= j + 1 && c <= j + D) eocc++;
         checks++; if (out_valid !== (c >= D && c < D + 3)) begin errors++; $display("FAIL stream_valid c=%0d got %b want %b", c, out_valid, (c >= D && c < D + 3)); end
         if (c >= D && c < D + 3) begin
            checks++; if (out_data !== vals[c-D]) begin errors++; $display("FAIL stream_data c=%0d got %h want %h", c, out_data, vals[c-D]); end
         end
         checks++; if (occupancy !== OW'(eocc)) begin errors++; $display("FAIL stream_occ c=%0d got %0d want %0d", c, occupancy, eocc); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got %b want 1", c, in_ready); end
         if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
         tick;
      end
      in_valid = 1'b0;
      checks++; if (maxocc != D) begin errors++; $display("FAIL stream_peak_occ got %0d want %0d", maxocc, D); end
   endtask

   task automatic test_backpressure;
      logic [N-1:0] pat [4];
      logic pv [4];
      pat[0] = 8'h11; pat[1] = 8'h00; pat[2] = 8'h22; pat[3] = 8'h33;
      pv[0] = 1'b1; pv[1] = 1'b0; pv[2] = 1'b1; pv[3] = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = pv[i];
         in_data = pat[i];
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready i=%0d got %b want 1", i, in_ready); end
         tick;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (occupancy !== OW'(D)) begin errors++; $display("FAIL bp_occ k=%0d got %0d want %0d", k, occupancy, D); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready k=%0d got %b want 0", k, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_data !== N'(8'h11)) begin errors++; $display("FAIL bp_head k=%0d got v=%b d=%h want 1 11", k, out_valid, out_data); end
         tick;
      end
   endtask

   task automatic test_pass_through;
      logic [N-1:0] q [$];
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h44;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pt_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== N'(8'h11)) begin errors++; $display("FAIL pt_pop got v=%b d=%h want 1 11", out_valid, out_data); end
      tick;
      in_valid = 1'b0;
      #1;
      checks++; if (occupancy !== OW'(D)) begin errors++; $display("FAIL pt_occ got %0d want %0d", occupancy, D); end
      q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
      for (int k = 0; k < 10 && q.size() > 0; k++) begin
         if (out_valid === 1'b1) begin
            checks++; if (out_data !== q[0]) begin errors++; $display("FAIL drain_data got %h want %h", out_data, q[0]); end
            void'(q.pop_front());
         end
         tick;
      end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL drain_timeout got %0d left want 0", q.size()); end
      checks++; if (occupancy !== '0) begin errors++; $display("FAIL drain_occ got %0d want 0", occupancy); end
   endtask

   task automatic test_flush;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'hAA; tick;
      in_data = 8'hBB; tick;
      in_valid = 1'b0; tick;
      checks++; if (occupancy !== OW'(2) || out_valid !== 1'b1) begin errors++; $display("FAIL preflush got occ=%0d v=%b want 2 1", occupancy, out_valid); end
      flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
      tick;
      flush = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (occupancy !== '0) begin errors++; $display("FAIL postflush_occ got %0d want 0", occupancy); end
      for (int k = 0; k < D + 2; k++) begin
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak k=%0d got v=%b d=%h want v=0", k, out_valid, out_data); end
         tick;
      end
   endtask

   task automatic test_random;
      logic [N-1:0] q [$];
      int tq [$];
      logic exp_ready, push, pop, fl;
      logic [N-1:0] din;
      int c0;
      for (int n = 0; n < 400; n++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 31) == 0);
         #1;
         exp_ready = !flush && !(q.size() == D && !out_ready);
         checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready n=%0d got %b want %b", n, in_ready, exp_ready); end
         checks++; if (occupancy !== OW'(q.size())) begin errors++; $display("FAIL rnd_occ n=%0d got %0d want %0d", n, occupancy, q.size()); end
         if (flush) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush_valid n=%0d got %b want 0", n, out_valid); end
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL rnd_spurious n=%0d got v=1 want empty", n); end
            else if (out_data !== q[0] || cyc - tq[0] < D) begin errors++; $display("FAIL rnd_pop n=%0d got %h age %0d want %h age>=%0d", n, out_data, cyc - tq[0], q[0], D); end
         end
         push = in_valid && exp_ready;
         pop = (out_valid === 1'b1) && out_ready && q.size() > 0;
         fl = flush;
         din = in_data;
         c0 = cyc;
         tick;
         if (fl) begin
            q.delete(); tq.delete();
         end else begin
            if (pop) begin void'(q.pop_front()); void'(tq.pop_front()); end
            if (push) begin q.push_back(din); tq.push_back(c0); end
         end
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4 * D && q.size() > 0; k++) begin
         #1;
         if (out_valid === 1'b1) begin
            checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rnd_drain got %h want %h", out_data, q[0]); end
            void'(q.pop_front());
         end
         tick;
      end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout got %0d left want 0", q.size()); end
   endtask

   task automatic test_share_isolation;
      logic [2:0] prev, base;
      i_out_ready = 1'b1; i_in_valid = 1'b1; i_flush = 1'b0;
      for (int n = 0; n < 16; n++) begin
         prev = 3'($urandom);
         i_in_data = prev;
         tick;
         checks++; if (i_out_valid !== 1'b1 || i_out_data !== prev) begin errors++; $display("FAIL iso_pass n=%0d got v=%b d=%b want 1 %b", n, i_out_valid, i_out_data, prev); end
      end
      base = 3'($urandom);
      i_in_data = base;
      tick;
      for (int s = 0; s < 3; s++) begin
         i_in_data = base ^ (3'b001 << s);
         tick;
         checks++; if ((i_out_data ^ base) !== (3'b001 << s)) begin errors++; $display("FAIL iso_toggle s=%0d got %b want %b", s, i_out_data, base ^ (3'b001 << s)); end
         i_in_data = base;
         tick;
         checks++; if (i_out_data !== base) begin errors++; $display("FAIL iso_restore s=%0d got %b want %b", s, i_out_data, base); end
      end
      i_in_valid = 1'b0;
   endtask

   initial begin
      test_reset;
      test_stream;
      test_backpressure;
      test_pass_through;
      test_flush;
      test_random;
      test_share_isolation;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
